// File: rtl/glitch_filter_pkg.sv
// Definitions shared by the glitch-filter bank and its sample/event scheduler.
package glitch_filter_pkg;

    localparam int unsigned MAX_CHANNELS    = 32;
    localparam int unsigned PERIOD_DISABLED = 0;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fes_rr_arbiter.sv
// Round-robin grant over a request vector; the search starts one past the last grant.
module fes_rr_arbiter
    import glitch_filter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = ch_width(N)
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid
);

    logic [IDX_W-1:0] r_last;

    always_comb begin
        int unsigned      w_idx;
        logic [IDX_W-1:0] w_sel;
        w_idx       = 0;
        w_sel       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            w_idx = 32'(r_last) + off;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_sel = IDX_W'(w_idx);
            if (!o_gnt_valid && i_req[w_sel]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_sel;
            end
        end
    end

    // Starting at N-1 gives channel 0 first priority out of reset.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_last <= IDX_W'(N - 1);
        end else if (i_advance && o_gnt_valid) begin
            r_last <= o_gnt_idx;
        end
    end

endmodule

// File: rtl/filter_ena_scheduler.sv
// Per-channel sample-enable strobes plus change-event reporting through one
// round-robin valid/ready port.
module filter_ena_scheduler
    import glitch_filter_pkg::*;
#(
    parameter int unsigned             NUM_CHANNELS = 4,
    parameter int unsigned             PERIOD_W     = 16,
    parameter logic [NUM_CHANNELS-1:0] RST_VALUE    = '0,
    parameter int unsigned             CH_W         = ch_width(NUM_CHANNELS)
) (
    input  logic                    iClk,
    input  logic                    iSRst,
    input  logic                    iRun,
    input  logic                    iCfgWe,
    input  logic [CH_W-1:0]         iCfgSel,
    input  logic [PERIOD_W-1:0]     iCfgPeriod,
    output logic [NUM_CHANNELS-1:0] oEna,
    input  logic [NUM_CHANNELS-1:0] iFiltered,
    output logic                    oEvtValid,
    input  logic                    iEvtReady,
    output logic [CH_W-1:0]         oEvtChan,
    output logic                    oEvtLevel,
    output logic [NUM_CHANNELS-1:0] oOvf,
    input  logic                    iOvfClr
);

    logic                    w_sel_ok;
    logic [NUM_CHANNELS-1:0] w_pend;
    logic [NUM_CHANNELS-1:0] w_level;
    logic [CH_W-1:0]         w_gnt_idx;
    logic                    w_gnt_valid;
    logic                    w_load_ok;
    logic                    w_load;

    logic                    r_evt_valid;
    logic [CH_W-1:0]         r_evt_chan;
    logic                    r_evt_level;

    assign w_sel_ok  = 32'(iCfgSel) < NUM_CHANNELS;
    assign w_load_ok = !r_evt_valid || iEvtReady;
    assign w_load    = w_load_ok && w_gnt_valid;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [PERIOD_W-1:0] r_period;
        logic [PERIOD_W-1:0] r_cnt;
        logic                r_ena;
        logic                r_hist;
        logic                r_pend;
        logic                r_level;
        logic                r_ovf;
        logic                w_wr;
        logic                w_change;
        logic                w_clr;

        assign w_wr     = iCfgWe && w_sel_ok && (iCfgSel == CH_W'(c));
        assign w_change = r_hist ^ iFiltered[c];
        assign w_clr    = w_load && (w_gnt_idx == CH_W'(c));

        always_ff @(posedge iClk) begin
            if (iSRst) begin
                r_period <= '0;
                r_cnt    <= '0;
                r_ena    <= 1'b0;
                r_hist   <= RST_VALUE[c];
                r_pend   <= 1'b0;
                r_level  <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                r_hist <= iFiltered[c];
                if (w_wr) begin
                    r_period <= iCfgPeriod;
                    r_cnt    <= iCfgPeriod - PERIOD_W'(1);
                    r_ena    <= 1'b0;
                end else if (iRun && (r_period != PERIOD_W'(PERIOD_DISABLED))) begin
                    if (r_cnt == '0) begin
                        r_ena <= 1'b1;
                        r_cnt <= r_period - PERIOD_W'(1);
                    end else begin
                        r_ena <= 1'b0;
                        r_cnt <= r_cnt - PERIOD_W'(1);
                    end
                end else begin
                    r_ena <= 1'b0;
                end
                // A change racing the load of this channel re-arms pending without overrun.
                if (w_change) begin
                    r_pend  <= 1'b1;
                    r_level <= iFiltered[c];
                end else if (w_clr) begin
                    r_pend <= 1'b0;
                end
                r_ovf <= (r_ovf && !iOvfClr) || (w_change && r_pend && !w_clr);
            end
        end

        assign oEna[c]    = r_ena;
        assign oOvf[c]    = r_ovf;
        assign w_pend[c]  = r_pend;
        assign w_level[c] = r_level;
    end

    fes_rr_arbiter #(
        .N     (NUM_CHANNELS),
        .IDX_W (CH_W)
    ) u_arb (
        .i_clk       (iClk),
        .i_srst      (iSRst),
        .i_req       (w_pend),
        .i_advance   (w_load_ok),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge iClk) begin
        if (iSRst) begin
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_evt_level <= 1'b0;
        end else if (w_load_ok) begin
            r_evt_valid <= w_gnt_valid;
            if (w_load) begin
                r_evt_chan  <= w_gnt_idx;
                r_evt_level <= w_level[w_gnt_idx];
            end
        end
    end

    assign oEvtValid = r_evt_valid;
    assign oEvtChan  = r_evt_chan;
    assign oEvtLevel = r_evt_level;

endmodule

// File: tb/tb_filter_ena_scheduler.sv
// Bench for filter_ena_scheduler: per-cycle model comparison plus directed literal checks.
module tb_filter_ena_scheduler;

    logic        iClk;
    logic        iSRst;
    logic        iRun;
    logic        iCfgWe;
    logic [1:0]  iCfgSel;
    logic [15:0] iCfgPeriod;
    logic [3:0]  oEna;
    logic [3:0]  iFiltered;
    logic        oEvtValid;
    logic        iEvtReady;
    logic [1:0]  oEvtChan;
    logic        oEvtLevel;
    logic [3:0]  oOvf;
    logic        iOvfClr;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    filter_ena_scheduler #(
        .NUM_CHANNELS (4),
        .PERIOD_W     (16),
        .RST_VALUE    (4'b0000)
    ) dut (
        .iClk       (iClk),
        .iSRst      (iSRst),
        .iRun       (iRun),
        .iCfgWe     (iCfgWe),
        .iCfgSel    (iCfgSel),
        .iCfgPeriod (iCfgPeriod),
        .oEna       (oEna),
        .iFiltered  (iFiltered),
        .oEvtValid  (oEvtValid),
        .iEvtReady  (iEvtReady),
        .oEvtChan   (oEvtChan),
        .oEvtLevel  (oEvtLevel),
        .oOvf       (oOvf),
        .iOvfClr    (iOvfClr)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Model: strobe when the count of running cycles since the write is a multiple
    // of the period; events drawn from a pending set scanned after the last grant.
    int        m_period[4];
    int        m_runs[4];
    bit  [3:0] m_ena, m_hist, m_pend, m_lvl, m_ovf;
    bit        m_valid, m_level;
    int        m_chan, m_last;

    always @(posedge iClk) begin
        bit [3:0] pend_o, lvl_o, hist_o;
        bit       valid_o;
        int       gnt;
        cyc++;
        if (iSRst) begin
            for (int c = 0; c < 4; c++) begin
                m_period[c] = 0;
                m_runs[c]   = 0;
            end
            m_ena = '0; m_hist = '0; m_pend = '0; m_lvl = '0; m_ovf = '0;
            m_valid = 0; m_level = 0; m_chan = 0; m_last = 3;
        end else begin
            pend_o = m_pend; lvl_o = m_lvl; hist_o = m_hist; valid_o = m_valid; gnt = -1;
            for (int c = 0; c < 4; c++) begin
                if (iCfgWe && int'(iCfgSel) == c) begin
                    m_period[c] = int'(iCfgPeriod);
                    m_runs[c]   = 0;
                    m_ena[c]    = 0;
                end else if (iRun && m_period[c] != 0) begin
                    m_runs[c]++;
                    m_ena[c] = (m_runs[c] % m_period[c]) == 0;
                end else begin
                    m_ena[c] = 0;
                end
            end
            if (!valid_o || iEvtReady) begin
                m_valid = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (gnt < 0 && pend_o[(m_last + k) % 4]) gnt = (m_last + k) % 4;
                end
                if (gnt >= 0) begin
                    m_valid = 1; m_chan = gnt; m_level = lvl_o[gnt]; m_last = gnt;
                end
            end
            if (iOvfClr) m_ovf = '0;
            for (int c = 0; c < 4; c++) begin
                if (hist_o[c] != iFiltered[c]) begin
                    if (pend_o[c] && c != gnt) m_ovf[c] = 1;
                    m_pend[c] = 1;
                    m_lvl[c]  = iFiltered[c];
                end else if (c == gnt) begin
                    m_pend[c] = 0;
                end
            end
            m_hist = iFiltered;
        end
    end

    always @(negedge iClk) begin
        if (cyc >= 1) begin
            check("model_ena", 32'(oEna), 32'(m_ena));
            check("model_valid", 32'(oEvtValid), 32'(m_valid));
            check("model_ovf", 32'(oOvf), 32'(m_ovf));
            if (m_valid) begin
                check("model_chan", 32'(oEvtChan), 32'(m_chan));
                check("model_level", 32'(oEvtLevel), 32'(m_level));
            end
        end
    end

    task automatic goto(input int unsigned n);
        while (cyc < n) @(negedge iClk);
    endtask

    task automatic expect_evt(input int unsigned n, input logic v, input logic [1:0] ch,
                              input logic lv);
        goto(n);
        check("evt_valid", 32'(oEvtValid), 32'(v));
        if (v) begin
            check("evt_chan", 32'(oEvtChan), 32'(ch));
            check("evt_level", 32'(oEvtLevel), 32'(lv));
        end
    endtask

    initial begin
        #20000;
        n_bad++;
        $display("FAIL watchdog: stimulus did not complete, got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp;
        iSRst = 1; iRun = 1; iCfgWe = 0; iCfgSel = 0; iCfgPeriod = 0;
        iFiltered = 4'b0000; iEvtReady = 1; iOvfClr = 0;

        goto(3);
        iSRst = 0;
        check("rst_ena", 32'(oEna), 32'h0);
        check("rst_valid", 32'(oEvtValid), 32'h0);
        check("rst_chan", 32'(oEvtChan), 32'h0);
        check("rst_level", 32'(oEvtLevel), 32'h0);
        check("rst_ovf", 32'(oOvf), 32'h0);

        goto(10);
        iCfgWe = 1; iCfgSel = 1; iCfgPeriod = 16'd3;
        // Pause covers cycles 25..29, pushing the strobe due at 26 to 31.
        for (int unsigned n = 11; n <= 48; n++) begin
            goto(n);
            if (n == 25) iRun = 0;
            if (n == 30) iRun = 1;
            if (n == 32) begin
                iCfgWe = 1; iCfgSel = 1; iCfgPeriod = 16'd0;
            end else if (n == 40) begin
                iCfgWe = 1; iCfgSel = 2; iCfgPeriod = 16'd1;
            end else if (n == 46) begin
                iCfgWe = 1; iCfgSel = 2; iCfgPeriod = 16'd0;
            end else begin
                iCfgWe = 0;
            end
            exp    = '0;
            exp[1] = (n == 14 || n == 17 || n == 20 || n == 23 || n == 31);
            exp[2] = (n >= 42 && n <= 46);
            check("ena_lit", 32'(oEna), 32'(exp));
        end

        goto(50); iFiltered = 4'b1101;
        expect_evt(52, 1, 2'd0, 1); expect_evt(53, 1, 2'd2, 1);
        expect_evt(54, 1, 2'd3, 1); expect_evt(55, 0, 2'd0, 0);

        goto(60); iFiltered = 4'b0000;
        expect_evt(62, 1, 2'd0, 0); expect_evt(63, 1, 2'd2, 0);
        expect_evt(64, 1, 2'd3, 0); expect_evt(65, 0, 2'd0, 0);

        goto(70); iFiltered = 4'b0100;
        expect_evt(72, 1, 2'd2, 1); expect_evt(73, 0, 2'd0, 0);

        goto(80); iFiltered = 4'b1101;
        expect_evt(82, 1, 2'd3, 1); expect_evt(83, 1, 2'd0, 1);
        expect_evt(84, 0, 2'd0, 0);

        goto(90); iEvtReady = 0;
        goto(91); iFiltered = 4'b1111;
        for (int unsigned n = 93; n <= 98; n++) begin
            expect_evt(n, 1, 2'd1, 1);
            if (n == 94) iFiltered = 4'b1101;
            if (n == 96) iFiltered = 4'b1111;
            if (n == 97) check("ovf_set", 32'(oOvf), 32'h2);
            if (n == 98) iEvtReady = 1;
        end
        expect_evt(99, 1, 2'd1, 1); expect_evt(100, 0, 2'd0, 0);
        goto(102); check("ovf_sticky", 32'(oOvf), 32'h2); iOvfClr = 1;
        goto(103); check("ovf_clr", 32'(oOvf), 32'h0); iOvfClr = 0;

        goto(108); iEvtReady = 0; iFiltered = 4'b1110;
        goto(109); iFiltered = 4'b1111;
        expect_evt(110, 1, 2'd0, 0);
        check("ovf_load_race", 32'(oOvf), 32'h0);
        goto(111); iFiltered = 4'b1110; iOvfClr = 1;
        goto(112); iOvfClr = 0; check("ovf_set_wins", 32'(oOvf), 32'h1);
        goto(114); iEvtReady = 1;
        expect_evt(115, 1, 2'd0, 0); expect_evt(116, 0, 2'd0, 0);

        goto(120); iCfgWe = 1; iCfgSel = 3; iCfgPeriod = 16'd2;
        goto(121); iCfgWe = 0; iEvtReady = 0; iFiltered = 4'b1100;
        goto(123); check("ena_p2", 32'(oEna), 32'h8);
        expect_evt(123, 1, 2'd1, 0);
        goto(125); iSRst = 1; iFiltered = 4'b0001;
        expect_evt(125, 1, 2'd1, 0);
        goto(126); iSRst = 0; iEvtReady = 1;
        check("srst_valid", 32'(oEvtValid), 32'h0);
        check("srst_chan", 32'(oEvtChan), 32'h0);
        check("srst_level", 32'(oEvtLevel), 32'h0);
        check("srst_ovf", 32'(oOvf), 32'h0);
        for (int unsigned n = 126; n <= 140; n++) begin
            goto(n);
            check("srst_ena", 32'(oEna), 32'h0);
            if (n == 127 || n == 129) expect_evt(n, 0, 2'd0, 0);
            if (n == 128) expect_evt(n, 1, 2'd0, 1);
        end

        goto(142);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filter_ena_scheduler.md
# filter_ena_scheduler

Sampling scheduler and change-event reporter for a bank of glitch-filter channels. Generates a per-channel one-cycle sample-enable strobe at a programmable period. Watches each filter's glitch-free output for level changes. Reports each change through a single valid/ready event port shared by all channels via round-robin arbitration. Sits between the filter bank and the system management logic that configures sample rates and consumes input-change events.

## Interface
- NUM_CHANNELS, 4, number of filter channels served (1..32)
- PERIOD_W, 16, width of a per-channel sample period
- RST_VALUE, 0, NUM_CHANNELS-bit reset level assumed for filter outputs (edge-detect history)
- iClk  in  1  clock; all logic on rising edge
- iSRst  in  1  synchronous reset, active-high
- iRun  in  1  global strobe enable; 0 freezes all period counters
- iCfgWe  in  1  period write strobe
- iCfgSel  in  CH_W  channel index for the write; CH_W = max(1, clog2(NUM_CHANNELS))
- iCfgPeriod  in  PERIOD_W  sample period P in cycles; 0 = channel disabled
- oEna  out  NUM_CHANNELS  per-channel sample-enable strobes, one bit per filter enable input
- iFiltered  in  NUM_CHANNELS  filtered outputs of the filter bank (same clock domain)
- oEvtValid  out  1  event available
- iEvtReady  in  1  consumer accepts event
- oEvtChan  out  CH_W  channel that changed
- oEvtLevel  out  1  new level of that channel
- oOvf  out  NUM_CHANNELS  sticky per-channel overrun flags
- iOvfClr  in  1  clears all oOvf bits

## Operation
- **Reset values:**
  - Outputs: oEna, oEvtValid, oEvtChan, oEvtLevel and oOvf are all 0.
  - Internal state: periods and counters are 0 (all channels disabled), pending bits are 0, and history equals RST_VALUE.
  - The round-robin pointer starts so that channel 0 has first priority.
- **Period write (iCfgWe=1):**
  - Writes period[sel] = iCfgPeriod and counter[sel] = iCfgPeriod-1. This restarts the channel's phase.
  - If iCfgSel ≥ NUM_CHANNELS, the write is ignored.
  - The written channel produces no strobe in the write cycle's update.
- **Strobe generation, per channel, each cycle with iRun=1 and period≠0:**
  - If counter==0: oEna[c] is registered to 1 and the counter reloads period-1.
  - Otherwise: the counter decrements and oEna[c] is registered to 0.
  - If iRun=0 or period==0: counter holds and oEna[c] is 0.
  - Channels are independent, so several oEna bits may be high in the same cycle.
- **Edge detection:**
  - history[c] is registered from iFiltered[c] every cycle.
  - A mismatch between history[c] and iFiltered[c] sets pending[c] and latches level[c] = iFiltered[c].
  - If pending[c] is already set when a new change arrives, level[c] is overwritten and oOvf[c] is set.
- **Event output stage (one register):**
  - The stage is loadable when it is empty, or when it is full and iEvtReady=1 (handshake this cycle).
  - When loadable, the next pending channel is chosen round-robin, starting after the last granted channel.
  - On load: chan and level go to the stage, pending[chan] clears, and the pointer updates.
  - Loading in the same cycle as a handshake sustains 1 event per cycle.
- **Simultaneous events:**
  - Change on the channel being loaded in the same cycle: pending stays set with the new level, not flagged as overrun.
  - iOvfClr in the same cycle as a new overrun: the set wins.
  - iSRst overrides everything, including mid-handshake; the held event is dropped.
- **Output stability:** oEvtValid, oEvtChan and oEvtLevel stay stable while oEvtValid=1 and iEvtReady=0.

## Timing
- **Strobe:**
  - With a write sampled at edge t and iRun=1, the first oEna[c] pulse is in cycle t+P+1, then every P cycles.
  - P=1 keeps oEna[c] continuously high from t+2.
- **Run toggling:** deasserting iRun for k cycles delays all later strobes by exactly k cycles.
- **Event latency:** an iFiltered change sampled at edge t sets pending at t+1. oEvtValid rises at t+2 if the stage is free.
- **Arbitration:** no channel waits more than NUM_CHANNELS handshakes once pending.

## Structure
- Shared package `glitch_filter_pkg` holds:
  - the CH_W clog2 helper;
  - the PERIOD_DISABLED=0 constant;
  - the NUM_CHANNELS range limit, shared with the filter bank.
- One sub-module: `fes_rr_arbiter`, a NUM_CHANNELS request vector plus advance strobe, producing a grant index and valid.
- Per-channel counters and edge detectors stay in generate loops in the top level.

## Test plan
- **Period 3:** write P=3 to ch1 at cycle 10 with iRun=1 → oEna[1] high in cycles 14, 17, 20; other bits stay 0.
- **Run pause:** drop iRun for 5 cycles after cycle 15 → the next ch1 strobe moves from 17 to 22. Then write P=0 → no further strobes.
- **Round-robin:** toggle iFiltered[0], [2] and [3] in one cycle with iEvtReady=1 → events ch0, ch2, ch3 on consecutive cycles, levels 1. Repeat the toggle → order continues from ch0 after the pointer.
- **Backpressure:** iEvtReady=0 for 8 cycles with ch1 toggling twice → the first event is held stable, oOvf[1]=1, and the delivered level equals the final level. iOvfClr then clears oOvf[1].
- **Reset mid-operation:** iSRst while oEvtValid=1 and counters are running → the next cycle shows all outputs 0 and all periods 0. After reset with RST_VALUE=0 and iFiltered=4'b0001 → one event ch0, level 1.
